// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Defining UART_LOADER_PARITY_EN adds an even-parity bit (8E1 framing).
package uart_loader_pkg;

    localparam int BYTE_WIDTH     = 8;
    localparam int BYTES_PER_WORD = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_LOADER_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// Bit-level UART receiver: synchronizer, mid-bit sampling FSM, byte/error strobes.
// Defining UART_LOADER_PARITY_EN inserts an even-parity check before the stop bit.
module uart_rx
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  byte_valid,
    output logic [BYTE_WIDTH-1:0] byte_data,
    output logic                  frame_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(BYTE_WIDTH);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_WIDTH - 1);

    rx_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [BYTE_WIDTH-1:0] shift_q, shift_d;
    logic                  sync1_q, sync2_q, prev_q;
    logic                  bit_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign bit_done  = (cnt_q == FULL_M1);
    assign byte_data = shift_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_valid  = 1'b0;
        frame_error = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                // edge, not level: a line held low after a bad stop bit must not retrigger
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[BYTE_WIDTH-1:1]};
                    if (bit_q == LAST_BIT) begin
`ifdef UART_LOADER_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_LOADER_PARITY_EN
            RX_PARITY: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (^shift_q ^ sync2_q) begin
                        frame_error = 1'b1;
                        state_d     = RX_IDLE;
                    end else begin
                        state_d = RX_STOP;
                    end
                end
            end
`endif
            RX_STOP: begin
                if (bit_done) begin
                    cnt_d       = '0;
                    state_d     = RX_IDLE;
                    byte_valid  = sync2_q;
                    frame_error = !sync2_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_program_loader.sv
// Assembles UART bytes into {opcode, address-field} words and writes them to sequential addresses.
// Defining UART_LOADER_PARITY_EN makes the receiver expect 8E1 frames.
module uart_program_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_WIDTH        = 8,
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
    parameter int CLKS_PER_BIT      = 434,
    parameter int TIMEOUT_BITS      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  addr_clear,
    output logic                  program_write,
    output logic [DATA_WIDTH-1:0] program_cmd,
    output logic [ADDR_WIDTH-1:0] uart_address,
    output logic                  loading,
    output logic                  frame_error
);

    localparam int PHASE_W        = $clog2(BYTES_PER_WORD);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GAP_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0]   GAP_MAX    = GAP_W'(TIMEOUT_CYCLES);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(BYTES_PER_WORD - 1);

    logic                         rx_valid, rx_ferr;
    logic [BYTE_WIDTH-1:0]        rx_data;

    logic [PHASE_W-1:0]           phase_q, phase_d;
    logic [INSTRUCTION_WIDTH-1:0] byte0_q, byte0_d;
    logic [DATA_WIDTH-1:0]        cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [GAP_W-1:0]             gap_q, gap_d;
    logic                         write_q, write_d;
    logic                         loading_q, loading_d;
    logic                         ferr_q, ferr_d;
    logic                         timeout;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_error(rx_ferr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q   <= '0;
            byte0_q   <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            gap_q     <= '0;
            write_q   <= 1'b0;
            loading_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            byte0_q   <= byte0_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            gap_q     <= gap_d;
            write_q   <= write_d;
            loading_q <= loading_d;
            ferr_q    <= ferr_d;
        end
    end

    // the gap counter only runs while a partial word is held
    assign timeout = (phase_q != '0) && (gap_q == GAP_MAX);

    always_comb begin
        phase_d   = phase_q;
        byte0_d   = byte0_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        write_d   = 1'b0;
        loading_d = loading_q;
        ferr_d    = rx_ferr;
        gap_d     = (phase_q != '0 && !timeout) ? gap_q + GAP_W'(1) : '0;

        if (write_q) addr_d = addr_q + ADDR_WIDTH'(1);

        if (rx_ferr) begin
            phase_d   = '0;
            loading_d = 1'b0;
        end else if (rx_valid) begin
            gap_d = '0;
            if (phase_q == LAST_PHASE) begin
                cmd_d     = DATA_WIDTH'({byte0_q, rx_data});
                write_d   = 1'b1;
                phase_d   = '0;
                loading_d = 1'b0;
            end else begin
                byte0_d   = rx_data[INSTRUCTION_WIDTH-1:0];
                phase_d   = phase_q + PHASE_W'(1);
                loading_d = 1'b1;
            end
        end else if (timeout) begin
            phase_d   = '0;
            loading_d = 1'b0;
        end

        // clear outranks a word completing in the same cycle
        if (addr_clear) begin
            addr_d    = '0;
            phase_d   = '0;
            write_d   = 1'b0;
            loading_d = 1'b0;
        end
    end

    assign program_write = write_q;
    assign program_cmd   = cmd_q;
    assign uart_address  = addr_q;
    assign loading       = loading_q;
    assign frame_error   = ferr_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized bench for uart_program_loader against a word-level reference model.
module tb_uart_program_loader;

    localparam int CPB = 16;
`ifdef UART_LOADER_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int BYTE_CYC = CPB * FRAME_BITS;
    // cycle within a frame where the receiver decides the stop bit
    localparam int STOP_C   = CPB * (FRAME_BITS - 1) + 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        addr_clear = 1'b0;
    logic        program_write;
    logic [11:0] program_cmd;
    logic [7:0]  uart_address;
    logic        loading;
    logic        frame_error;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .addr_clear   (addr_clear),
        .program_write(program_write),
        .program_cmd  (program_cmd),
        .uart_address (uart_address),
        .loading      (loading),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    typedef logic [19:0] wr_t;  // {cmd, addr}
    wr_t  obs_q[$], exp_q[$];
    wr_t  o, e;
    int   n_cmp = 0, n_bad = 0;
    int   fe_cnt = 0, exp_fe = 0;
    logic [3:0] m_b0 = '0;
    logic       m_phase = 1'b0;
    logic [7:0] m_addr = '0;

    always @(negedge clk) begin
        if (program_write === 1'b1) obs_q.push_back({program_cmd, uart_address});
        if (frame_error === 1'b1) fe_cnt++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input bit good_stop, input int clear_at);
        logic [10:0] fr;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = b;
`ifdef UART_LOADER_PARITY_EN
        fr[9]  = ^b;
        fr[10] = good_stop;
`else
        fr[9] = good_stop;
`endif
        for (int c = 0; c < BYTE_CYC; c++) begin
            @(negedge clk);
            rx = fr[c / CPB];
            addr_clear = (c == clear_at);
        end
        @(negedge clk);
        rx = 1'b1;
        addr_clear = 1'b0;
    endtask

    // word-level reference: two good bytes make one write at the running address
    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_phase = 1'b0;
            exp_fe++;
        end else if (!m_phase) begin
            m_b0 = b[3:0];
            m_phase = 1'b1;
        end else begin
            exp_q.push_back({m_b0, b, m_addr});
            m_addr++;
            m_phase = 1'b0;
        end
    endtask

    task automatic tx(input logic [7:0] b, input bit good);
        send_byte(b, good, -1);
        model_byte(b, good);
    endtask

    task automatic tx_word();
        tx(8'($urandom), 1'b1);
        tx(8'($urandom), 1'b1);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        n_cmp += 5;
        if (program_write !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %b need 0", program_write); end
        if (program_cmd !== 12'h0) begin n_bad++; $display("FAIL reset_cmd: got %h need 000", program_cmd); end
        if (uart_address !== 8'h0) begin n_bad++; $display("FAIL reset_addr: got %h need 00", uart_address); end
        if (loading !== 1'b0) begin n_bad++; $display("FAIL reset_loading: got %b need 0", loading); end
        if (frame_error !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b need 0", frame_error); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_basic();
        tx(8'h05, 1'b1);
        n_cmp++;
        if (loading !== m_phase) begin n_bad++; $display("FAIL basic_loading_hi: got %b need %b", loading, m_phase); end
        tx(8'hA3, 1'b1);
        n_cmp++;
        if (loading !== m_phase) begin n_bad++; $display("FAIL basic_loading_lo: got %b need %b", loading, m_phase); end
        tx_word();
        repeat (20) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== 2 || obs_q[0] !== 20'h5A3_00) begin
            n_bad++; $display("FAIL basic_first: got %0d writes, first %h, need 2 writes, first 5a300", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 20'h0);
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL basic_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL basic_write: got %h/%h need %h/%h", o[19:8], o[7:0], e[19:8], e[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        repeat (4) tx_word();
        repeat (20) @(negedge clk);
        n_cmp += 2;
        if (fe_cnt !== exp_fe) begin n_bad++; $display("FAIL random_ferr: got %0d need %0d", fe_cnt, exp_fe); end
        if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL random_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL random_write: got %h/%h need %h/%h", o[19:8], o[7:0], e[19:8], e[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        n_cmp += 3;
        if (fe_cnt !== exp_fe) begin n_bad++; $display("FAIL glitch_ferr: got %0d need %0d", fe_cnt, exp_fe); end
        if (obs_q.size() !== 0) begin n_bad++; $display("FAIL glitch_write: got %0d writes need 0", obs_q.size()); end
        if (loading !== m_phase) begin n_bad++; $display("FAIL glitch_loading: got %b need %b", loading, m_phase); end
        tx_word();
        repeat (20) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL glitch_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL glitch_after: got %h/%h need %h/%h", o[19:8], o[7:0], e[19:8], e[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_frame_error();
        logic [7:0] a0;
        a0 = m_addr;
        tx(8'($urandom), 1'b1);
        tx(8'($urandom), 1'b0);
        n_cmp += 2;
        if (fe_cnt !== exp_fe) begin n_bad++; $display("FAIL ferr_pulse: got %0d need %0d", fe_cnt, exp_fe); end
        if (loading !== 1'b0) begin n_bad++; $display("FAIL ferr_loading: got %b need 0", loading); end
        tx_word();
        repeat (20) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL ferr_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        if (obs_q.size() > 0) begin
            n_cmp++;
            if (obs_q[0][7:0] !== a0) begin n_bad++; $display("FAIL ferr_addr: got %h need %h", obs_q[0][7:0], a0); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL ferr_write: got %h/%h need %h/%h", o[19:8], o[7:0], e[19:8], e[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout();
        tx(8'h0C, 1'b1);
        n_cmp++;
        if (loading !== 1'b1) begin n_bad++; $display("FAIL timeout_loading_hi: got %b need 1", loading); end
        repeat (40 * CPB) @(negedge clk);
        m_phase = 1'b0;  // a 40-bit gap exceeds the 32-bit timeout
        n_cmp++;
        if (loading !== 1'b0) begin n_bad++; $display("FAIL timeout_loading_lo: got %b need 0", loading); end
        tx(8'h01, 1'b1);
        tx(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        n_cmp += 2;
        if (fe_cnt !== exp_fe) begin n_bad++; $display("FAIL timeout_ferr: got %0d need %0d", fe_cnt, exp_fe); end
        if (obs_q.size() !== 1 || obs_q[0][19:8] !== 12'h122) begin
            n_bad++; $display("FAIL timeout_cmd: got %0d writes, cmd %h, need 1 write, cmd 122", obs_q.size(), obs_q.size() > 0 ? obs_q[0][19:8] : 12'h0);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL timeout_write: got %h/%h need %h/%h", o[19:8], o[7:0], e[19:8], e[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap();
        int n;
        n = 257 - int'(m_addr);
        repeat (n) tx_word();
        repeat (20) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL wrap_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        if (obs_q.size() >= 2) begin
            n_cmp += 2;
            if (obs_q[obs_q.size()-2][7:0] !== 8'hFF) begin n_bad++; $display("FAIL wrap_last: got %h need ff", obs_q[obs_q.size()-2][7:0]); end
            if (obs_q[obs_q.size()-1][7:0] !== 8'h00) begin n_bad++; $display("FAIL wrap_roll: got %h need 00", obs_q[obs_q.size()-1][7:0]); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL wrap_write: got %h/%h need %h/%h", o[19:8], o[7:0], e[19:8], e[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_addr_clear();
        logic [7:0] b;
        while (m_addr != 8'h07) tx_word();
        tx(8'($urandom), 1'b1);
        // clear lands in the very cycle byte 1 completes
        send_byte(8'($urandom), 1'b1, STOP_C);
        m_addr = '0;
        m_phase = 1'b0;
        n_cmp++;
        if (loading !== 1'b0) begin n_bad++; $display("FAIL clear_loading: got %b need 0", loading); end
        tx_word();
        // clear mid-byte: that byte becomes byte 0 of the restarted sequence
        tx(8'($urandom), 1'b1);
        b = 8'($urandom);
        send_byte(b, 1'b1, 5 * CPB);
        m_addr = '0;
        m_phase = 1'b0;
        model_byte(b, 1'b1);
        tx(8'($urandom), 1'b1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL clear_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL clear_write: got %h/%h need %h/%h", o[19:8], o[7:0], e[19:8], e[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_byte();
        tx(8'($urandom), 1'b1);
        fork
            send_byte(8'($urandom), 1'b1, -1);
            begin
                repeat (70) @(negedge clk);
                #2 reset = 1'b1;
                #1;
                n_cmp += 4;
                if (program_write !== 1'b0) begin n_bad++; $display("FAIL rmid_write: got %b need 0", program_write); end
                if (uart_address !== 8'h0) begin n_bad++; $display("FAIL rmid_addr: got %h need 00", uart_address); end
                if (loading !== 1'b0) begin n_bad++; $display("FAIL rmid_loading: got %b need 0", loading); end
                if (program_cmd !== 12'h0) begin n_bad++; $display("FAIL rmid_cmd: got %h need 000", program_cmd); end
            end
        join
        repeat (20) @(negedge clk);
        reset = 1'b0;
        m_addr = '0;
        m_phase = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== 0) begin n_bad++; $display("FAIL rmid_nowrite: got %0d writes need 0", obs_q.size()); end
        tx_word();
        repeat (20) @(negedge clk);
        n_cmp += 2;
        if (fe_cnt !== exp_fe) begin n_bad++; $display("FAIL rmid_ferr: got %0d need %0d", fe_cnt, exp_fe); end
        if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rmid_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL rmid_write: got %h/%h need %h/%h", o[19:8], o[7:0], e[19:8], e[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_glitch();
        test_frame_error();
        test_timeout();
        test_wrap();
        test_addr_clear();
        test_reset_mid_byte();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
